// File: rtl/insn_loader.sv
// insn_loader: boot loader that parses a little-endian byte stream (word count N,
// then N 32-bit words) and writes the words to instruction memory from address 0.
// The CPU is held in reset until the program is loaded; ebreak re-arms the loader.
module insn_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WORDS  = 4096
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  input  logic                  ebreak_i,
  output logic                  insn_mem_wen_o,
  output logic [ADDR_WIDTH-1:0] insn_mem_waddr_o,
  output logic [31:0]           insn_o,
  output logic                  cpu_rstn_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [1:0]  ST_HDR  = 2'd0;
  localparam logic [1:0]  ST_LOAD = 2'd1;
  localparam logic [1:0]  ST_RUN  = 2'd2;
  localparam logic [1:0]  ST_ERR  = 2'd3;
  localparam logic [31:0] MAX_N   = 32'(MAX_WORDS);

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [1:0]            byte_cnt_r;
  logic [31:0]           asm_r;
  logic [31:0]           n_r;
  logic [ADDR_WIDTH-1:0] idx_r;
  logic                  ready_r;
  logic                  err_r;
  logic                  wen_r;
  logic [ADDR_WIDTH-1:0] waddr_r;
  logic [31:0]           insn_r;
  logic                  run_r;

  logic                  xfer_s;
  logic                  word_done_s;
  logic [31:0]           word_s;
  logic                  last_word_s;
  logic                  rearm_s;

  assign xfer_s      = byte_valid_i & ready_r;
  assign word_done_s = xfer_s & (byte_cnt_r == 2'd3);
  // The completing byte lands in the top lane; lower lanes are already assembled.
  assign word_s      = {byte_i, asm_r[23:0]};
  assign last_word_s = (({{(32-ADDR_WIDTH){1'b0}}, idx_r} + 32'd1) == n_r);
  assign rearm_s     = (state_r == ST_RUN) & ebreak_i;

  // Next-state selection for the header / load / run / error sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HDR: begin
        if (word_done_s) begin
          if (word_s == 32'd0) begin
            state_nxt_s = ST_RUN;
          end else if (word_s > MAX_N) begin
            state_nxt_s = ST_ERR;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_LOAD: begin
        if (word_done_s && last_word_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (ebreak_i) begin
          state_nxt_s = ST_HDR;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_ERR:  state_nxt_s = ST_ERR;
      default: state_nxt_s = ST_HDR;
    endcase
  end

  // State register plus ready/error flags registered from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= ST_HDR;
      ready_r <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_HDR) || (state_nxt_s == ST_LOAD);
      err_r   <= (state_nxt_s == ST_ERR);
    end
  end

  // Byte assembly, word count capture and word index tracking.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      byte_cnt_r <= 2'd0;
      asm_r      <= 32'd0;
      n_r        <= 32'd0;
      idx_r      <= '0;
    end else if (rearm_s) begin
      byte_cnt_r <= 2'd0;
      asm_r      <= 32'd0;
      n_r        <= 32'd0;
      idx_r      <= '0;
    end else if (xfer_s) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      asm_r[{byte_cnt_r, 3'b000} +: 8] <= byte_i;
      if (word_done_s && (state_r == ST_HDR)) begin
        n_r   <= word_s;
        idx_r <= '0;
      end else if (word_done_s && (state_r == ST_LOAD)) begin
        idx_r <= idx_r + 1'b1;
      end
    end
  end

  // Instruction-memory write port: one-cycle enable, address/data held otherwise.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wen_r   <= 1'b0;
      waddr_r <= '0;
      insn_r  <= 32'd0;
    end else if (word_done_s && (state_r == ST_LOAD)) begin
      wen_r   <= 1'b1;
      waddr_r <= idx_r;
      insn_r  <= word_s;
    end else begin
      wen_r   <= 1'b0;
    end
  end

  // CPU release lags entry into RUN by one cycle and drops as soon as ebreak re-arms.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      run_r <= 1'b0;
    end else begin
      run_r <= (state_r == ST_RUN) && !ebreak_i;
    end
  end

  assign byte_ready_o     = ready_r;
  assign err_o            = err_r;
  assign insn_mem_wen_o   = wen_r;
  assign insn_mem_waddr_o = waddr_r;
  assign insn_o           = insn_r;
  assign cpu_rstn_o       = run_r;
  assign done_o           = run_r;

endmodule

// File: tb/tb_insn_loader.sv
// tb_insn_loader: randomized scoreboard bench for insn_loader. Programs are built
// from a word list; the expected memory writes are queued when a program is issued
// and a free-running monitor pops and compares them whenever a write pulse appears.
module tb_insn_loader;

  localparam int AW   = 12;
  localparam int MAXW = 4096;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          byte_valid;
  logic [7:0]    byte_d;
  logic          byte_ready;
  logic          ebreak;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [31:0]   insn;
  logic          cpu_rstn;
  logic          done;
  logic          err;

  int            checks = 0;
  int            errors = 0;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [31:0]   words_q[$];
  logic [7:0]    stream_q[$];
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;
  logic          prev_wen;
  bit            mon_en;
  int            wen_count;

  insn_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .byte_valid_i     (byte_valid),
    .byte_i           (byte_d),
    .byte_ready_o     (byte_ready),
    .ebreak_i         (ebreak),
    .insn_mem_wen_o   (wen),
    .insn_mem_waddr_o (waddr),
    .insn_o           (insn),
    .cpu_rstn_o       (cpu_rstn),
    .done_o           (done),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare every write pulse against the scoreboard, check hold otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (wen === 1'b1) begin
          check1("wen_single_cycle", prev_wen, 1'b0);
          wen_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%h:%h required=none", waddr, insn);
          end else begin
            mon_e = exp_q.pop_front();
            checkw("write_addr", 32'(waddr), 32'(mon_e.addr));
            checkw("write_data", insn, mon_e.data);
            last_addr = mon_e.addr;
            last_data = mon_e.data;
          end
        end else begin
          checkw("waddr_hold", 32'(waddr), 32'(last_addr));
          checkw("insn_hold", insn, last_data);
        end
        prev_wen = wen;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit rand_eb);
    int idle;
    int waits;
    idle = (gap == 1) ? 2 : ((gap == 2) ? int'($urandom_range(0, 3)) : 0);
    repeat (idle) begin
      byte_valid = 1'b0;
      byte_d     = 8'($urandom);
      ebreak     = rand_eb ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
    end
    ebreak = 1'b0;
    waits  = 0;
    while (byte_ready !== 1'b1 && waits < 50) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (waits >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout actual=0 required=1");
    end else begin
      byte_valid = 1'b1;
      byte_d     = b;
      ebreak     = rand_eb ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      ebreak     = 1'b0;
    end
  endtask

  // Reference model: header = N little-endian, then words; writes go to 0..N-1.
  task automatic load_program(input logic [31:0] n, input int gap, input bit rand_eb);
    int base;
    bit ok;
    ok = (n <= 32'(MAXW));
    stream_q.delete();
    for (int k = 0; k < 4; k++) stream_q.push_back(8'(n >> (8 * k)));
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        for (int k = 0; k < 4; k++) stream_q.push_back(8'(words_q[i] >> (8 * k)));
        exp_q.push_back({AW'(i), words_q[i]});
      end
    end
    base = wen_count;
    foreach (stream_q[i]) send_byte(stream_q[i], gap, rand_eb);
    if (ok) begin
      check1("done_low_before_run", done, 1'b0);
      check1("ready_low_in_run", byte_ready, 1'b0);
      @(posedge clk);
      #1;
      check1("done_after_load", done, 1'b1);
      check1("cpu_rstn_after_load", cpu_rstn, 1'b1);
      check1("ready_low_after_load", byte_ready, 1'b0);
      check1("err_low", err, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checkw("write_count", 32'(wen_count - base), n);
      checkw("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check1("done_held", done, 1'b1);
    end else begin
      check1("err_set", err, 1'b1);
      check1("err_ready_low", byte_ready, 1'b0);
      check1("err_cpu_rstn_low", cpu_rstn, 1'b0);
      ebreak = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      ebreak = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check1("err_held", err, 1'b1);
      check1("err_ready_held_low", byte_ready, 1'b0);
      check1("err_cpu_rstn_held_low", cpu_rstn, 1'b0);
      check1("err_done_low", done, 1'b0);
      checkw("err_no_writes", 32'(wen_count - base), 32'd0);
    end
  endtask

  task automatic rearm();
    ebreak = 1'b1;
    @(posedge clk);
    #1;
    ebreak = 1'b0;
    check1("rearm_cpu_rstn_low", cpu_rstn, 1'b0);
    check1("rearm_done_low", done, 1'b0);
    check1("rearm_ready_high", byte_ready, 1'b1);
  endtask

  task automatic apply_reset();
    mon_en     = 1'b0;
    rstn       = 1'b0;
    byte_valid = 1'b0;
    ebreak     = 1'b0;
    #3;
    check1("rst_ready", byte_ready, 1'b1);
    check1("rst_wen", wen, 1'b0);
    checkw("rst_waddr", 32'(waddr), 32'd0);
    checkw("rst_insn", insn, 32'd0);
    check1("rst_cpu_rstn", cpu_rstn, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    exp_q.delete();
    last_addr = '0;
    last_data = 32'd0;
    prev_wen  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    check1("post_rst_ready", byte_ready, 1'b1);
  endtask

  task automatic set_case1();
    words_q.delete();
    words_q.push_back(32'h0000_0013);
    words_q.push_back(32'h0010_0073);
  endtask

  initial begin
    rstn       = 1'b0;
    byte_valid = 1'b0;
    byte_d     = 8'd0;
    ebreak     = 1'b0;
    mon_en     = 1'b0;
    wen_count  = 0;
    prev_wen   = 1'b0;
    last_addr  = '0;
    last_data  = 32'd0;
    #12;
    apply_reset();

    set_case1();
    load_program(32'd2, 0, 1'b0);
    rearm();
    load_program(32'd2, 1, 1'b0);
    rearm();
    words_q.delete();
    load_program(32'd0, 0, 1'b0);
    rearm();
    words_q.delete();
    words_q.push_back(32'hDEAD_BEEF);
    load_program(32'd1, 0, 1'b0);
    rearm();

    for (int p = 0; p < 6; p++) begin
      logic [31:0] n;
      n = 32'($urandom_range(1, 8));
      words_q.delete();
      for (int i = 0; i < int'(n); i++) words_q.push_back($urandom);
      load_program(n, 2, 1'b1);
      rearm();
    end

    set_case1();
    stream_q.delete();
    stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
    foreach (stream_q[i]) send_byte(stream_q[i], 0, 1'b0);
    apply_reset();
    load_program(32'd2, 0, 1'b0);

    apply_reset();
    words_q.delete();
    load_program(32'd4097, 0, 1'b0);
    apply_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
